// File: rtl/la_status_sequencer.sv
// Logic-analyzer driven LFSR self-test sequencer: launches a signature run, reports status on io_out.
// Optional completion interrupt enabled with macro LA_SEQ_IRQ_EN.
module la_status_sequencer (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [63:0] la_data_in,
  input  logic [63:0] la_oenb,
  output logic [63:0] la_data_out,
  output logic [4:0]  io_out,
  output logic [4:0]  io_oeb,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CHECK = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  function automatic logic [4:0] status_code(input state_t st);
    case (st)
      RUN, CHECK: status_code = 5'b00010;
      PASS:       status_code = 5'b00001;
      FAIL:       status_code = 5'b11110;
      default:    status_code = 5'b00000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t      state, state_n;
  logic [15:0] lfsr, lfsr_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] sig, sig_n;
  logic        start_q;

  logic        start_eff;
  logic        abort_eff;
  logic [7:0]  len_eff;
  logic [15:0] seed_eff;
  logic [15:0] sig_eff;
  logic        start_edge;
  logic        unused_cmd;

  assign start_eff  = la_data_in[0] & ~la_oenb[0];
  assign abort_eff  = la_data_in[1] & ~la_oenb[1];
  assign len_eff    = la_data_in[15:8]  & ~la_oenb[15:8];
  assign seed_eff   = la_data_in[31:16] & ~la_oenb[31:16];
  assign sig_eff    = la_data_in[47:32] & ~la_oenb[47:32];
  assign start_edge = start_eff & ~start_q;
  assign unused_cmd = ^{la_data_in[63:48], la_data_in[7:2], la_oenb[63:48], la_oenb[7:2]};

  // Next-state: abort dominates everything, including a coincident start edge
  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    sig_n   = sig;
    if (abort_eff) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (start_edge) begin
            state_n = RUN;
            lfsr_n  = (seed_eff == 16'd0) ? SEED_DEFAULT : seed_eff;
            cnt_n   = len_eff;
            sig_n   = sig_eff;
          end
        end
        RUN: begin
          if (cnt != 8'd0) begin
            lfsr_n = lfsr_step(lfsr);
            cnt_n  = cnt - 8'd1;
          end else begin
            state_n = CHECK;
          end
        end
        CHECK: begin
          state_n = (lfsr == sig) ? PASS : FAIL;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and status registers; io_out tracks the state it is registered alongside
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      lfsr    <= '0;
      cnt     <= '0;
      sig     <= '0;
      io_out  <= 5'b00000;
      start_q <= 1'b1;
    end else begin
      state   <= state_n;
      lfsr    <= lfsr_n;
      cnt     <= cnt_n;
      sig     <= sig_n;
      io_out  <= status_code(state_n);
      start_q <= start_eff;
    end
  end

`ifdef LA_SEQ_IRQ_EN
  logic irq_q;

  // Only the CHECK exit reaches PASS/FAIL, so this fires once per completed run
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (state == CHECK) && ((state_n == PASS) || (state_n == FAIL));
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign la_data_out = {37'd0, 3'(state), cnt, lfsr};
  assign io_oeb      = 5'b00000;

endmodule

// File: doc/la_status_sequencer.md
LA_STATUS_SEQUENCER -- requirements
Module: la_status_sequencer

Interface
REQ-001 SHALL have port: wb_clk_i  in  1  sole clock.
REQ-002 SHALL have port: wb_rst_i  in  1  synchronous reset, active-high.
REQ-003 SHALL have port: la_data_in  in  64  management command.
  - [0] start
  - [1] abort
  - [15:8] run length N
  - [31:16] seed
  - [47:32] expected signature
  - others ignored
REQ-004 SHALL have port: la_oenb  in  64  per-bit enable, active-low. Effective bit = la_data_in[i] AND NOT la_oenb[i].
REQ-005 SHALL have port: la_data_out  out  64  status readback.
  - [15:0] lfsr
  - [23:16] cnt
  - [26:24] state encoding
  - others 0
REQ-006 SHALL have port: io_out  out  5  status code; wrapper maps it to mprj_io[24:20].
REQ-007 SHALL have port: io_oeb  out  5  constant 5'b00000 (always driving).
REQ-008 SHALL have port: irq  out  1  one-cycle completion pulse.

Function
REQ-009 SHALL implement FSM states IDLE=0, RUN=1, CHECK=2, PASS=3, FAIL=4.
REQ-010 SHALL drive io_out by state, registered:
  - IDLE 5'b00000
  - RUN or CHECK 5'b00010
  - PASS 5'b00001
  - FAIL 5'b11110
REQ-011 SHALL register effective start into start_q each cycle. start_edge = start AND NOT start_q.
REQ-012 SHALL act on start_edge in IDLE, PASS or FAIL:
  - next state RUN
  - lfsr <= seed, or 16'hACE1 if seed==0
  - cnt <= N
  - expected signature latched
REQ-013 SHALL ignore start_edge in RUN and CHECK.
REQ-014 In RUN with cnt!=0, SHALL each cycle:
  - set lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}
  - decrement cnt
REQ-015 In RUN with cnt==0, SHALL go to CHECK with lfsr held. N=0 therefore produces zero LFSR steps.
REQ-016 In CHECK, SHALL go to PASS if lfsr equals the latched expected value, else to FAIL.
REQ-017 Latency: start_edge in cycle t SHALL result in PASS/FAIL state in cycle t+N+3 and io_out updated in the same cycle as the state.
REQ-018 PASS and FAIL SHALL hold until start_edge or abort.
REQ-019 Effective abort SHALL force IDLE next cycle from any state, with cnt cleared and lfsr held. Abort has priority over a simultaneous start_edge.
REQ-020 Changes to la_data_in after launch SHALL NOT affect a run in progress, except abort.
REQ-021 cnt SHALL never wrap below 0.

Reset
REQ-022 On wb_rst_i=1 at a clock edge, SHALL set:
  - state IDLE
  - lfsr 0, cnt 0
  - expected 0
  - io_out 5'b00000
  - la_data_out 0
  - irq 0
REQ-023 SHALL reset start_q to 1, so a start bit held high across reset does not launch a run; start must deassert and reassert.
REQ-024 Reset mid-RUN SHALL abandon the run with no irq pulse.

Configuration
REQ-025 SHALL use macro LA_SEQ_IRQ_EN to control irq.
  - Defined: irq pulses high for exactly one cycle in the cycle the state first becomes PASS or FAIL.
  - Undefined: irq is tied to 0 and no irq logic is synthesized.
  - All other behaviour is identical in both builds.

Verification
REQ-026 N=0, seed=0x1234, expected=0x1234, pulse start -> io_out 00010 for 2 cycles, then 00001; irq single pulse if LA_SEQ_IRQ_EN.
REQ-027 N=0, seed=0x1234, expected=0x1235 -> io_out 11110; la_data_out[26:24]=4.
REQ-028 N=1, seed=0x0001, expected=0x0002 -> PASS, la_data_out[15:0]=0x0002. Also N=3, seed=0x0001, expected=0x0008 -> PASS at edge+6 cycles.
REQ-029 N=200, start; abort asserted at cycle 50 together with a new start edge -> IDLE next cycle, io_out 00000, cnt=0, no irq; second start edge after abort deasserts -> normal run.
REQ-030 Start held high through reset release -> stays IDLE. Start toggled during RUN -> ignored, result unchanged.
REQ-031 Bits with la_oenb=1 (e.g. start high, la_oenb[0]=1) -> no launch. seed=0 -> lfsr loads 0xACE1.
